// File: rtl/terrain_crater.sv
// Crater carving engine: read-modify-write of terrain columns, clearing solid
// bits inside a disc of radius r centred at (cx, cy).
//
// state  | meaning
// IDLE   | wait for start, latch cx/cy/r
// SETUP  | clip column range, x = x_lo, h = r
// HCALC  | shrink h until (x, cy +/- h) lies on the disc
// READ   | read_addr = x, terrain read in flight
// MODIFY | clear rows y_lo..y_hi of the returned column
// WRITE  | we = 1, advance to next column or finish
// DONE   | one-cycle done pulse
module terrain_crater #(
   parameter int NCOLS = 640,
   parameter int FLOOR = 479
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [9:0]   center_x,
   input  logic [9:0]   center_y,
   input  logic [5:0]   radius,
   input  logic [511:0] terrain_out,
   output logic [9:0]   read_addr,
   output logic [9:0]   write_addr,
   output logic         we,
   output logic [511:0] terrain_in,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {IDLE, SETUP, HCALC, READ, MODIFY, WRITE, DONE} state_t;

   localparam logic signed [11:0] LAST_COL = 12'(NCOLS - 1);
   localparam logic signed [11:0] FLOOR_S  = 12'(FLOOR);

   state_t state, state_nxt;

   logic [9:0]          cx, cy;
   logic [5:0]          r, h;
   logic signed [11:0]  x;

   logic signed [11:0]  cx_s, cy_s, r_s, h_s;
   logic signed [11:0]  x_lo_raw, x_hi_raw, x_lo, x_hi;
   logic signed [11:0]  dx, y_lo_raw, y_hi_raw;
   logic [11:0]         dx_abs, dx_sq, h_sq, r_sq, y_lo, y_hi;
   logic [12:0]         dist_sq;
   logic                outside;
   logic [511:0]        clr_mask;

   assign cx_s = signed'({2'b00, cx});
   assign cy_s = signed'({2'b00, cy});
   assign r_s  = signed'({6'b0, r});
   assign h_s  = signed'({6'b0, h});

   assign x_lo_raw = cx_s - r_s;
   assign x_hi_raw = cx_s + r_s;
   assign x_lo     = (x_lo_raw < 12'sd0) ? 12'sd0 : x_lo_raw;
   assign x_hi     = (x_hi_raw > LAST_COL) ? LAST_COL : x_hi_raw;

   // |dx| <= r <= 63, so the 12-bit squares are exact
   assign dx      = x - cx_s;
   assign dx_abs  = dx[11] ? $unsigned(-dx) : $unsigned(dx);
   assign dx_sq   = dx_abs * dx_abs;
   assign h_sq    = {6'b0, h} * {6'b0, h};
   assign r_sq    = {6'b0, r} * {6'b0, r};
   assign dist_sq = {1'b0, h_sq} + {1'b0, dx_sq};
   assign outside = dist_sq > {1'b0, r_sq};

   assign y_lo_raw = cy_s - h_s;
   assign y_hi_raw = cy_s + h_s;
   assign y_lo     = y_lo_raw[11] ? 12'd0 : $unsigned(y_lo_raw);
   assign y_hi     = (y_hi_raw > FLOOR_S) ? $unsigned(FLOOR_S) : $unsigned(y_hi_raw);

   // y_hi never exceeds FLOOR, so rows above FLOOR are never in the mask
   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < 512; i++) begin
         clr_mask[i] = (12'(i) >= y_lo) && (12'(i) <= y_hi);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   state_nxt = (x_lo > LAST_COL) ? DONE : HCALC;
         HCALC:   if (!outside) state_nxt = READ;
         READ:    state_nxt = MODIFY;
         MODIFY:  state_nxt = WRITE;
         WRITE:   state_nxt = (x == x_hi) ? DONE : HCALC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx         <= '0;
         cy         <= '0;
         r          <= '0;
         h          <= '0;
         x          <= '0;
         read_addr  <= '0;
         write_addr <= '0;
         terrain_in <= '0;
         we         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         we   <= (state_nxt == WRITE);
         case (state)
            IDLE: if (start) begin
               cx <= center_x;
               cy <= center_y;
               r  <= radius;
            end
            SETUP: if (x_lo <= LAST_COL) begin
               x         <= x_lo;
               h         <= r;
               read_addr <= x_lo[9:0];
            end
            HCALC: if (outside) h <= h - 6'd1;
            MODIFY: begin
               terrain_in <= terrain_out & ~clr_mask;
               write_addr <= x[9:0];
            end
            WRITE: if (x != x_hi) begin
               x         <= x + 12'sd1;
               h         <= r;
               read_addr <= read_addr + 10'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_terrain_crater.sv
// Bench for terrain_crater: terrain memory model, write scoreboard built from
// an independent disc model, table of requests plus a mid-operation reset.
module tb_terrain_crater;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [9:0]   center_x, center_y;
   logic [5:0]   radius;
   logic [511:0] terrain_out;
   logic [9:0]   read_addr, write_addr;
   logic         we;
   logic [511:0] terrain_in;
   logic         busy, done;

   always #5 clk = ~clk;

   terrain_crater dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .center_x(center_x), .center_y(center_y), .radius(radius),
      .terrain_out(terrain_out), .read_addr(read_addr), .write_addr(write_addr),
      .we(we), .terrain_in(terrain_in), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [9:0]   addr;
      logic [511:0] data;
   } wr_t;

   typedef struct {
      int cx, cy, r, nwr, busy;
      bit noise;
   } vec_t;

   logic [511:0] tmem   [640];
   logic [511:0] shadow [640];
   wr_t          sb[$];

   int total = 0, bad = 0;
   int busy_cnt = 0, done_cnt = 0, wr_cnt = 0;

   function automatic int col_h(int dx, int r);
      int rem, h;
      rem = r * r - dx * dx;
      h = 0;
      while ((h + 1) * (h + 1) <= rem) h++;
      return h;
   endfunction

   function automatic void carve(int x, int cy, int h);
      wr_t e;
      e.addr = 10'(x);
      e.data = shadow[x];
      for (int i = 0; i < 480; i++)
         if (i >= cy - h && i <= cy + h) e.data[i] = 1'b0;
      shadow[x] = e.data;
      sb.push_back(e);
   endfunction

   // pushes expected writes and returns the expected busy cycle count
   function automatic int push_model(int cx, int cy, int r);
      int lo, hi, cyc, h;
      lo  = (cx - r < 0) ? 0 : cx - r;
      hi  = (cx + r > 639) ? 639 : cx + r;
      cyc = 2;
      for (int x = lo; x <= hi; x++) begin
         h = col_h(x - cx, r);
         cyc += r - h + 4;
         carve(x, cy, h);
      end
      return cyc;
   endfunction

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic mem_proc();
      forever begin
         @(posedge clk);
         terrain_out <= tmem[read_addr];
         if (we) tmem[write_addr] <= terrain_in;
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (we) begin
               wr_cnt++;
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL extra_write got addr=%0d want no write", write_addr);
               end else begin
                  e = sb.pop_front();
                  if (write_addr !== e.addr || terrain_in !== e.data) begin
                     bad++;
                     $display("FAIL write_col got addr=%0d data=%h want addr=%0d data=%h",
                              write_addr, terrain_in, e.addr, e.data);
                  end
               end
            end
         end
      end
   endtask

   task automatic run_req(input vec_t v);
      int b0, d0, w0, mb, cyc;
      bit seen;
      mb = push_model(v.cx, v.cy, v.r);
      b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt;
      @(negedge clk);
      start    = 1'b1;
      center_x = 10'(v.cx);
      center_y = 10'(v.cy);
      radius   = 6'(v.r);
      @(negedge clk);
      start = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 20000) begin
         @(negedge clk);
         #1;
         cyc++;
         if (done_cnt != d0) seen = 1;
         else if (v.noise) begin
            start    = (cyc % 3 == 1);
            center_x = 10'($urandom_range(0, 639));
            center_y = 10'($urandom_range(0, 479));
            radius   = 6'($urandom_range(0, 63));
         end
      end
      start = 1'b0;
      check("done_seen", int'(seen), 1);
      check("done_pulses", done_cnt - d0, 1);
      check("busy_model", busy_cnt - b0, mb);
      if (v.busy != 0) check("busy_table", busy_cnt - b0, v.busy);
      check("write_count", wr_cnt - w0, v.nwr);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      vec_t vt[9];
      int   w0, cyc, nbad;

      vt[0] = '{cx:100, cy:310,  r:2,  nwr:5,   busy:28, noise:0};
      vt[1] = '{cx:0,   cy:479,  r:0,  nwr:1,   busy:6,  noise:0};
      vt[2] = '{cx:1,   cy:300,  r:5,  nwr:7,   busy:41, noise:0};
      vt[3] = '{cx:642, cy:300,  r:5,  nwr:3,   busy:22, noise:0};
      vt[4] = '{cx:700, cy:300,  r:5,  nwr:0,   busy:2,  noise:0};
      vt[5] = '{cx:50,  cy:2,    r:10, nwr:21,  busy:0,  noise:0};
      vt[6] = '{cx:300, cy:1000, r:63, nwr:127, busy:0,  noise:0};
      vt[7] = '{cx:639, cy:479,  r:63, nwr:64,  busy:0,  noise:0};
      vt[8] = '{cx:320, cy:400,  r:7,  nwr:15,  busy:0,  noise:1};

      reset_n = 1'b0; start = 1'b0;
      center_x = '0; center_y = '0; radius = '0;
      for (int c = 0; c < 640; c++) begin
         for (int w = 0; w < 16; w++) shadow[c][w*32 +: 32] = $urandom;
         shadow[c][511:310] = '1;
         tmem[c] = shadow[c];
      end
      fork
         mem_proc();
         monitor();
      join_none

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(we), 0);
      check("rst_read_addr", int'(read_addr), 0);
      check("rst_write_addr", int'(write_addr), 0);
      check("rst_terrain_in", int'(terrain_in != '0), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) run_req(vt[i]);

      @(negedge clk);
      #1;
      check("idle_after_done_busy", int'(busy), 0);
      check("idle_after_done_done", int'(done), 0);

      // reset during MODIFY of the third column (cols 1..3, col 3 has 2 HCALC cycles)
      carve(1, 320, col_h(-1, 1));
      carve(2, 320, col_h(0, 1));
      w0 = wr_cnt;
      @(negedge clk);
      start = 1'b1; center_x = 10'd2; center_y = 10'd320; radius = 6'd1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (wr_cnt != w0 + 2 && cyc < 1000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("rst_seq_two_writes", wr_cnt - w0, 2);
      repeat (4) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_we", int'(we), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("midrst_idle", int'(busy), 0);
      check("midrst_sb_empty", sb.size(), 0);
      check("midrst_col1", int'(tmem[1] === shadow[1]), 1);
      check("midrst_col2", int'(tmem[2] === shadow[2]), 1);
      check("midrst_col3_unchanged", int'(tmem[3] === shadow[3]), 1);

      nbad = 0;
      for (int c = 0; c < 640; c++) if (tmem[c] !== shadow[c]) nbad++;
      check("final_mem_cols_bad", nbad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
